window_agg_mc: RTL and testbench

- Multi-channel, frame-aware box-window aggregator for the stereo matching cost path. Generalised successor of the single-channel square-window SHD summer.
- Sums NCH independent cost channels (one per disparity candidate) over a WW-wide by WH-high window, using per-column running sums and a horizontal running sum.
- Tracks line and frame position internally, masks data from outside the frame, flags when the window is fully inside the image, and detects short lines.

---
 rtl/window_agg_mc.sv | 156 +++++++++++++++
 tb/tb_window_agg_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_agg_mc.sv
// Multi-channel box-window cost aggregator: per-column running sums held in memory,
// a horizontal running sum per channel, internal line/frame tracking and short-line flagging.
module window_agg_mc #(
   parameter  int NCH = 4,
   parameter  int IW  = 5,
   parameter  int WW  = 13,
   parameter  int WH  = 13,
   parameter  int M   = 650,
   localparam int CW  = IW + $clog2(WH),
   localparam int OW  = IW + $clog2(WW * WH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_dval,
   input  logic              i_sof,
   input  logic              i_sol,
   input  logic [NCH*IW-1:0] i_data_add,
   input  logic [NCH*IW-1:0] i_data_sub,
   output logic              o_dval,
   output logic              o_win_ok,
   output logic              o_line_err,
   output logic [NCH*OW-1:0] o_data
);
   localparam int RW = $clog2(WH + 1);
   localparam int XW = $clog2(M);

   logic [RW-1:0] row_q, row_n, row_inc;
   logic [XW-1:0] col_q, col_n;
   logic          first_q, err_q, err_n, restart, sub_on;

   // Position of the incoming beat; row saturates at WH, which is all the masking needs.
   always_comb begin
      restart = i_sof | first_q;
      row_inc = (row_q == RW'(WH)) ? row_q : row_q + RW'(1);
      row_n   = row_q;
      col_n   = col_q + XW'(1);
      err_n   = err_q;
      if (restart) begin
         row_n = '0;
         col_n = '0;
         err_n = 1'b0;
      end else if (i_sol) begin
         row_n = row_inc;
         col_n = '0;
         if (col_q != XW'(M - 1)) err_n = 1'b1;
      end else if (col_q == XW'(M - 1)) begin
         row_n = row_inc;
         col_n = '0;
      end
      sub_on = (int'(row_n) >= WH);
   end

   logic               v0, zero0, win0, err0;
   logic [XW-1:0]      col0;
   logic signed [IW:0] d0 [NCH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v0      <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         first_q <= 1'b1;
         err_q   <= 1'b0;
         zero0   <= 1'b1;
         win0    <= 1'b0;
         err0    <= 1'b0;
         col0    <= '0;
         for (int c = 0; c < NCH; c++) d0[c] <= '0;
      end else begin
         v0 <= i_dval;
         if (i_dval) begin
            row_q   <= row_n;
            col_q   <= col_n;
            first_q <= 1'b0;
            err_q   <= err_n;
            zero0   <= (row_n == '0);
            col0    <= col_n;
            err0    <= err_n;
            win0    <= (int'(row_n) >= WH - 1) && (int'(col_n) >= WW - 1);
            for (int c = 0; c < NCH; c++)
               d0[c] <= {1'b0, i_data_add[c*IW +: IW]}
                        - (sub_on ? {1'b0, i_data_sub[c*IW +: IW]} : (IW + 1)'(0));
         end
      end
   end

   logic              v1, win1, err1;
   logic [XW-1:0]     col1;
   logic [NCH*CW-1:0] cs_n, cs1;
   logic [NCH*CW-1:0] colmem [M];

   // Row 0 ignores whatever an earlier frame left in the column memory.
   always_comb begin
      cs_n = '0;
      for (int c = 0; c < NCH; c++)
         cs_n[c*CW +: CW] = (zero0 ? CW'(0) : colmem[col0][c*CW +: CW]) + CW'(d0[c]);
   end

   always_ff @(posedge i_clk) begin
      if (v0 && !i_rst) colmem[col0] <= cs_n;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1   <= 1'b0;
         win1 <= 1'b0;
         err1 <= 1'b0;
         col1 <= '0;
         cs1  <= '0;
      end else begin
         v1 <= v0;
         if (v0) begin
            win1 <= win0;
            err1 <= err0;
            col1 <= col0;
            cs1  <= cs_n;
         end
      end
   end

   logic [NCH*CW-1:0] hdly [WW];
   logic [NCH*OW-1:0] hs_n;

   // The column sum leaving the window was pushed WW beats ago, same line once col >= WW.
   always_comb begin
      hs_n = '0;
      for (int c = 0; c < NCH; c++)
         hs_n[c*OW +: OW] = ((col1 == '0) ? OW'(0) : o_data[c*OW +: OW])
                            + OW'(cs1[c*CW +: CW])
                            - ((int'(col1) >= WW) ? OW'(hdly[WW-1][c*CW +: CW]) : OW'(0));
   end

   always_ff @(posedge i_clk) begin
      if (v1 && !i_rst) begin
         hdly[0] <= cs1;
         for (int k = WW - 1; k > 0; k--) hdly[k] <= hdly[k-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_dval     <= 1'b0;
         o_win_ok   <= 1'b0;
         o_line_err <= 1'b0;
         o_data     <= '0;
      end else begin
         o_dval <= v1;
         if (v1) begin
            o_data     <= hs_n;
            o_win_ok   <= win1;
            o_line_err <= err1;
         end
      end
   end

endmodule

// File: tb/tb_window_agg_mc.sv
// Bench for window_agg_mc: directed frames with randomized pixels, each output beat
// compared against a reference that sums the window of column sums directly.
module tb_window_agg_mc;
   localparam int NCH = 2;
   localparam int IW  = 4;
   localparam int WW  = 3;
   localparam int WH  = 3;
   localparam int M   = 8;
   localparam int CW  = IW + $clog2(WH);
   localparam int OW  = IW + $clog2(WW * WH);
   localparam int DW  = NCH * IW;

   logic              clk = 1'b0;
   logic              rst, dval, sof, sol;
   logic [DW-1:0]     add, sub;
   logic              o_dval, o_win_ok, o_line_err;
   logic [NCH*OW-1:0] o_data;

   window_agg_mc #(.NCH(NCH), .IW(IW), .WW(WW), .WH(WH), .M(M)) dut (
      .i_clk(clk), .i_rst(rst), .i_dval(dval), .i_sof(sof), .i_sol(sol),
      .i_data_add(add), .i_data_sub(sub),
      .o_dval(o_dval), .o_win_ok(o_win_ok), .o_line_err(o_line_err), .o_data(o_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH*OW-1:0] data;
      logic              ok;
      logic              err;
      int                k0, k1, kok, kerr;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0, errors = 0;
   int   k0 = -1, k1 = -1, kok = -1, kerr = -1;
   int   m_row, m_col;
   bit   m_first, m_err;
   int   colsum [M][NCH];
   int   line_cs [M][NCH];
   int   img [32][M][NCH];
   bit   mon_on = 1'b0, rst_chk = 1'b0;
   logic [2:0] dly;
   int   cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   always @(posedge clk) dly <= rst ? 3'b000 : {dly[1:0], dval};

   always @(negedge clk) begin
      if (mon_on) begin
         chk("o_dval_vs_idval_delay3", {31'd0, o_dval}, {31'd0, dly[2]});
         if (rst_chk) begin
            chk("rst_o_data", 32'(o_data), 32'd0);
            chk("rst_o_win_ok", {31'd0, o_win_ok}, 32'd0);
            chk("rst_o_line_err", {31'd0, o_line_err}, 32'd0);
         end
         if (o_dval === 1'b1) begin
            chk("output_expected", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
               mon_e = q.pop_front();
               chk("o_data", 32'(o_data), 32'(mon_e.data));
               chk("o_win_ok", {31'd0, o_win_ok}, {31'd0, mon_e.ok});
               chk("o_line_err", {31'd0, o_line_err}, {31'd0, mon_e.err});
               if (mon_e.k0 >= 0) chk("const_ch0", 32'(o_data[OW-1:0]), mon_e.k0);
               if (mon_e.k1 >= 0) chk("const_ch1", 32'(o_data[2*OW-1:OW]), mon_e.k1);
               if (mon_e.kok >= 0) chk("const_win_ok", {31'd0, o_win_ok}, mon_e.kok);
               if (mon_e.kerr >= 0) chk("const_line_err", {31'd0, o_line_err}, mon_e.kerr);
            end
         end
      end
   end

   task automatic model_reset();
      m_row = 0;
      m_col = 0;
      m_first = 1'b1;
      m_err = 1'b0;
      q.delete();
   endtask

   task automatic clear_img();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < M; c++)
            for (int ch = 0; ch < NCH; ch++) img[r][c][ch] = 0;
   endtask

   // One valid beat; the expected window sum is the plain sum of up to WW column sums.
   task automatic px(input bit f_sof, input bit f_sol, input int br, input int bc, input int mode);
      int a, s, r, c, x, hs, lo;
      bit short_l;
      exp_t e;
      logic [DW-1:0] va, vs;
      short_l = 1'b0;
      if (f_sof || m_first) begin
         r = 0; c = 0;
      end else if (f_sol) begin
         r = (m_row < WH) ? m_row + 1 : WH; c = 0; short_l = (m_col != M - 1);
      end else if (m_col == M - 1) begin
         r = (m_row < WH) ? m_row + 1 : WH; c = 0;
      end else begin
         r = m_row; c = m_col + 1;
      end
      m_err = (f_sof || m_first) ? 1'b0 : (m_err | short_l);
      m_first = 1'b0;
      m_row = r;
      m_col = c;
      va = '0;
      vs = '0;
      e.data = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         case (mode)
            0:       a = ch + 1;
            1:       a = 15;
            3:       a = 7;
            default: a = int'($urandom_range(0, 15));
         endcase
         img[br][bc][ch] = a;
         s = (br >= WH) ? img[br-WH][bc][ch] : int'($urandom_range(0, 15));
         va[ch*IW +: IW] = a[IW-1:0];
         vs[ch*IW +: IW] = s[IW-1:0];
         x = ((r == 0) ? 0 : colsum[c][ch]) + a - ((r < WH) ? 0 : s);
         colsum[c][ch] = x & (2**CW - 1);
         line_cs[c][ch] = colsum[c][ch];
         lo = (c - WW + 1 > 0) ? c - WW + 1 : 0;
         hs = 0;
         for (int k = lo; k <= c; k++) hs += line_cs[k][ch];
         e.data[ch*OW +: OW] = hs[OW-1:0];
      end
      e.ok = (r >= WH - 1) && (c >= WW - 1);
      e.err = m_err;
      e.k0 = k0; e.k1 = k1; e.kok = kok; e.kerr = kerr;
      k0 = -1; k1 = -1; kok = -1; kerr = -1;
      q.push_back(e);
      dval = 1'b1; sof = f_sof; sol = f_sol; add = va; sub = vs;
      @(posedge clk); #1;
      cyc++;
      dval = 1'b0;
   endtask

   task automatic idle();
      dval = 1'b0;
      sof = 1'($urandom_range(0, 1));
      sol = 1'($urandom_range(0, 1));
      add = DW'($urandom);
      sub = DW'($urandom);
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dval = (i == 0);
         sof = 1'($urandom_range(0, 1));
         sol = 1'($urandom_range(0, 1));
         add = DW'($urandom);
         sub = DW'($urandom);
         @(posedge clk); #1;
         model_reset();
         mon_on = 1'b1;
         rst_chk = 1'b1;
      end
      rst = 1'b0;
      dval = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_chk = 1'b0;
   endtask

   // Pixels are indexed r*M+c; start/stop select a slice of the frame.
   task automatic frame(input int rows, input int mode, input bit bub, input bit use_sol,
                        input int short_r, input int start, input int stop);
      int w, idx;
      if (start == 0) clear_img();
      for (int r = 0; r < rows; r++) begin
         w = (r == short_r) ? 5 : M;
         for (int c = 0; c < w; c++) begin
            idx = r * M + c;
            if (idx < start) continue;
            if (stop >= 0 && idx >= stop) return;
            if (bub && (cyc % 3 == 2)) idle();
            if (idx == 0) kerr = 0;
            if (mode == 0) begin
               if (r == 0 && c == 0) begin k0 = 1; k1 = 2; kok = 0; end
               else if (r == 1 && c == 1) begin k0 = 4; k1 = 8; end
               else if (r >= 2 && c >= 2) begin k0 = 9; k1 = 18; kok = 1; end
            end
            if (mode == 1 && r >= 2 && c >= 2) begin k0 = 135; k1 = 135; kok = 1; end
            if (short_r >= 0) begin
               if (r == short_r && c == 4) kerr = 0;
               if (r > short_r) kerr = 1;
            end
            px(idx == 0, use_sol && c == 0, r, c, mode);
         end
      end
   endtask

   initial begin
      rst = 1'b1; dval = 1'b0; sof = 1'b0; sol = 1'b0; add = '0; sub = '0;
      model_reset();
      clear_img();
      do_reset();

      frame(5, 0, 1'b0, 1'b1, -1, 0, -1);
      frame(5, 0, 1'b1, 1'b1, -1, 0, -1);
      frame(5, 2, 1'b1, 1'b1, -1, 0, -1);
      frame(6, 2, 1'b0, 1'b0, -1, 0, -1);
      frame(5, 1, 1'b0, 1'b1, -1, 0, -1);

      // restart mid-frame at row 5, col 4
      frame(6, 2, 1'b0, 1'b1, -1, 0, 5 * M + 4);
      clear_img();
      k0 = 7; k1 = 7; kok = 0; kerr = 0;
      px(1'b1, 1'b0, 0, 0, 3);
      frame(4, 2, 1'b0, 1'b1, -1, 1, -1);

      frame(6, 2, 1'b0, 1'b1, 2, 0, -1);
      frame(3, 0, 1'b0, 1'b1, -1, 0, -1);

      // reset mid-frame; the next beat starts a frame without i_sof
      frame(3, 2, 1'b0, 1'b1, -1, 0, 2 * M + 3);
      do_reset();
      clear_img();
      px(1'b0, 1'b0, 0, 0, 2);
      frame(4, 2, 1'b0, 1'b1, -1, 1, -1);

      repeat (6) idle();
      chk("all_outputs_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
